// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : Instruction fetch front end. Owns the PC, issues one word-aligned
//             request at a time to a handshaked instruction memory, buffers
//             returned words in an in-order fetch queue and presents the head
//             (with its PC+4) to the IF/ID boundary. Handles freeze, branch
//             redirects and discarding of responses from a flushed path.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_stage #(
    parameter int             N        = 32,
    parameter logic [N-1:0]   RESET_PC = '0,
    parameter int             FQ_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_ack,
    input  logic         imem_rvalid,
    input  logic [N-1:0] imem_rdata,
    input  logic         freeze,
    input  logic         branch_taken,
    input  logic [N-1:0] branch_addr,
    output logic         if_valid,
    output logic [N-1:0] if_instruction,
    output logic [N-1:0] if_pc
);

    localparam int            AW      = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(FQ_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_REQ       = 3'd1,
        S_WAIT      = 3'd2,
        S_WAIT_DROP = 3'd3,
        S_FULL      = 3'd4
    } state_t;

    state_t         state, state_next;
    logic [N-1:0]   pc, pc_next;
    logic [N-1:0]   target;

    // Fetch queue storage: each entry holds PC+4 and the instruction word.
    logic [N-1:0]   q_pc   [FQ_DEPTH];
    logic [N-1:0]   q_inst [FQ_DEPTH];
    logic [AW-1:0]  rptr, wptr;
    logic [AW:0]    count, count_next, count_after_push;
    logic           push, pop;

    assign target           = {branch_addr[N-1:2], 2'b00};
    assign pop              = if_valid && !freeze && !branch_taken;
    assign count_after_push = count + (AW+1)'(1) - (AW+1)'(pop);

    // Next-state, next-PC and push decisions; a branch overrides everything.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        push       = 1'b0;
        case (state)
            S_IDLE:      state_next = S_REQ;
            S_REQ: begin
                if (imem_ack) begin
                    pc_next    = pc + N'(4);
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    push       = 1'b1;
                    state_next = (count_after_push < DEPTH_C) ? S_REQ : S_FULL;
                end
            end
            S_WAIT_DROP: begin
                if (imem_rvalid) state_next = S_REQ;
            end
            S_FULL: begin
                if (pop) state_next = S_REQ;
            end
            default:     state_next = S_IDLE;
        endcase

        if (branch_taken) begin
            push    = 1'b0;
            pc_next = target;
            case (state)
                S_WAIT:      state_next = imem_rvalid ? S_REQ : S_WAIT_DROP;
                S_REQ:       state_next = imem_ack    ? S_WAIT_DROP : S_REQ;
                S_WAIT_DROP: state_next = imem_rvalid ? S_REQ : S_WAIT_DROP;
                default:     state_next = S_REQ;
            endcase
        end
    end

    // Occupancy update: flush on branch, otherwise push/pop net change.
    always_comb begin
        count_next = count;
        if (branch_taken)
            count_next = '0;
        else
            count_next = count + (AW+1)'(push) - (AW+1)'(pop);
    end

    // State, PC and queue pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            count <= count_next;
            if (branch_taken) begin
                rptr <= '0;
                wptr <= '0;
            end else begin
                if (push) wptr <= wptr + AW'(1);
                if (pop)  rptr <= rptr + AW'(1);
            end
        end
    end

    // Queue entry write; pc already holds request address + 4 while in WAIT.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wptr]   <= pc;
            q_inst[wptr] <= imem_rdata;
        end
    end

    assign imem_req       = (state == S_REQ);
    assign imem_addr      = {pc[N-1:2], 2'b00};
    assign if_valid       = (count != '0);
    assign if_instruction = if_valid ? q_inst[rptr] : '0;
    assign if_pc          = if_valid ? q_pc[rptr]   : '0;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_stage
//  Purpose  : Directed self-checking bench for fetch_stage with a 1-cycle
//             handshaked instruction memory model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = '0;
    logic        if_valid;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;

    int total = 0;
    int bad   = 0;

    logic        mem_pause = 1'b0;
    logic        owed = 1'b0;
    logic [31:0] owed_addr = '0;

    fetch_stage #(.N(32), .RESET_PC(32'h0), .FQ_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .freeze(freeze), .branch_taken(branch_taken), .branch_addr(branch_addr),
        .if_valid(if_valid), .if_instruction(if_instruction), .if_pc(if_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr(input logic [31:0] a);
        return (a == 32'h0) ? 32'hE3A00014 : (a ^ 32'h5A5A0000);
    endfunction

    // Memory model: accept a request, answer it on the following cycle.
    always @(negedge clk) begin
        imem_ack    = 1'b0;
        imem_rvalid = 1'b0;
        if (owed) begin
            if (!mem_pause) begin
                imem_rvalid = 1'b1;
                imem_rdata  = instr(owed_addr);
                owed        = 1'b0;
            end
        end else if (imem_req) begin
            imem_ack  = 1'b1;
            owed      = 1'b1;
            owed_addr = imem_addr;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input string nm);
        logic ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (if_valid) begin ok = 1'b1; break; end
            step();
        end
        total++;
        if (!ok) begin bad++; $display("FAIL %s: if_valid never rose", nm); end
    endtask

    task automatic wait_ack(input string nm);
        logic ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (imem_ack) begin ok = 1'b1; break; end
            step();
        end
        total++;
        if (!ok) begin bad++; $display("FAIL %s: no imem_ack seen", nm); end
    endtask

    task automatic wait_rvalid(input string nm);
        logic ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (imem_rvalid) begin ok = 1'b1; break; end
            step();
        end
        total++;
        if (!ok) begin bad++; $display("FAIL %s: no imem_rvalid seen", nm); end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (imem_req !== 1'b0 || if_valid !== 1'b0 || if_instruction !== 32'h0 || if_pc !== 32'h0) begin
                bad++;
                $display("FAIL reset_hold: req=%b valid=%b instr=%h pc=%h, want 0 0 0 0",
                         imem_req, if_valid, if_instruction, if_pc);
            end
        end
        total++;
        if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
        rst = 1'b1;
        wait_ack("reset_first_req");
        total++;
        if (imem_addr !== 32'h0) begin bad++; $display("FAIL first_req_addr: got %h want 0", imem_addr); end
        wait_valid("reset_first_valid");
        total++;
        if (if_instruction !== 32'hE3A00014) begin bad++; $display("FAIL first_instr: got %h want e3a00014", if_instruction); end
        total++;
        if (if_pc !== 32'h4) begin bad++; $display("FAIL first_pc: got %h want 4", if_pc); end
        wait_ack("reset_second_req");
        total++;
        if (imem_addr !== 32'h4) begin bad++; $display("FAIL next_fetch_addr: got %h want 4", imem_addr); end
    endtask

    task automatic test_freeze_fill();
        logic req_seen = 1'b0;
        rst = 1'b0;
        step();
        step();
        freeze = 1'b1;
        rst = 1'b1;
        wait_valid("ff_first_valid");
        total++;
        if (if_instruction !== 32'hE3A00014 || if_pc !== 32'h4) begin
            bad++; $display("FAIL ff_head: got %h/%h want e3a00014/4", if_instruction, if_pc);
        end
        for (int i = 0; i < 3; i++) step();
        for (int i = 0; i < 4; i++) begin
            if (imem_req) req_seen = 1'b1;
            step();
        end
        total++;
        if (req_seen !== 1'b0) begin bad++; $display("FAIL ff_full_req: got req=1 while full, want 0"); end
        total++;
        if (if_valid !== 1'b1 || if_instruction !== 32'hE3A00014 || if_pc !== 32'h4) begin
            bad++; $display("FAIL ff_head_held: got %b %h/%h want 1 e3a00014/4", if_valid, if_instruction, if_pc);
        end
        freeze = 1'b0;
        step();
        total++;
        if (if_valid !== 1'b1 || if_instruction !== instr(32'h4) || if_pc !== 32'h8) begin
            bad++; $display("FAIL ff_pop2: got %b %h/%h want 1 %h/8", if_valid, if_instruction, if_pc, instr(32'h4));
        end
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
            bad++; $display("FAIL ff_next_req: got req=%b addr=%h want 1/8", imem_req, imem_addr);
        end
    endtask

    task automatic test_branch_wait();
        wait_ack("bw_ack");
        mem_pause = 1'b1;
        step();
        branch_taken = 1'b1;
        branch_addr  = 32'h70;
        step();
        branch_taken = 1'b0;
        total++;
        if (imem_addr !== 32'h70 || if_valid !== 1'b0 || imem_req !== 1'b0) begin
            bad++; $display("FAIL bw_redirect: got addr=%h valid=%b req=%b want 70/0/0", imem_addr, if_valid, imem_req);
        end
        mem_pause = 1'b0;
        wait_valid("bw_valid");
        total++;
        if (if_pc !== 32'h74 || if_instruction !== instr(32'h70)) begin
            bad++; $display("FAIL bw_target: got %h/%h want %h/74", if_instruction, if_pc, instr(32'h70));
        end
    endtask

    task automatic test_simultaneous();
        freeze = 1'b1;
        wait_rvalid("sim_rvalid");
        branch_taken = 1'b1;
        branch_addr  = 32'h100;
        step();
        branch_taken = 1'b0;
        total++;
        if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            bad++; $display("FAIL sim_flush: got valid=%b req=%b addr=%h want 0/1/100", if_valid, imem_req, imem_addr);
        end
        wait_valid("sim_valid");
        total++;
        if (if_pc !== 32'h104 || if_instruction !== instr(32'h100)) begin
            bad++; $display("FAIL sim_head: got %h/%h want %h/104", if_instruction, if_pc, instr(32'h100));
        end
        freeze = 1'b0;
    endtask

    task automatic test_wrap();
        branch_taken = 1'b1;
        branch_addr  = 32'hFFFFFFFE;
        step();
        branch_taken = 1'b0;
        total++;
        if (imem_addr !== 32'hFFFFFFFC) begin bad++; $display("FAIL wrap_addr: got %h want fffffffc", imem_addr); end
        wait_valid("wrap_valid");
        total++;
        if (if_pc !== 32'h0 || if_instruction !== instr(32'hFFFFFFFC)) begin
            bad++; $display("FAIL wrap_head: got %h/%h want %h/0", if_instruction, if_pc, instr(32'hFFFFFFFC));
        end
        wait_ack("wrap_next_ack");
        total++;
        if (imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_next_addr: got %h want 0", imem_addr); end
    endtask

    task automatic test_midreset();
        branch_taken = 1'b1;
        branch_addr  = 32'h300;
        step();
        branch_taken = 1'b0;
        wait_valid("mr_valid");
        wait_ack("mr_ack");
        total++;
        if (imem_addr !== 32'h304) begin bad++; $display("FAIL mr_req_addr: got %h want 304", imem_addr); end
        mem_pause = 1'b1;
        step();
        branch_taken = 1'b1;
        branch_addr  = 32'h200;
        step();
        branch_taken = 1'b0;
        total++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h200) begin
            bad++; $display("FAIL mr_drop_state: got req=%b addr=%h want 0/200", imem_req, imem_addr);
        end
        rst = 1'b0;
        step();
        total++;
        if (imem_req !== 1'b0 || if_valid !== 1'b0 || imem_addr !== 32'h0) begin
            bad++; $display("FAIL mr_in_reset: got req=%b valid=%b addr=%h want 0/0/0", imem_req, if_valid, imem_addr);
        end
        rst = 1'b1;
        mem_pause = 1'b0;
        wait_valid("mr_restart_valid");
        total++;
        if (if_instruction !== 32'hE3A00014 || if_pc !== 32'h4) begin
            bad++; $display("FAIL mr_restart_head: got %h/%h want e3a00014/4", if_instruction, if_pc);
        end
    endtask

    initial begin
        test_reset();
        test_freeze_fill();
        test_branch_wait();
        test_simultaneous();
        test_wrap();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
